// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, the combinational instruction ROM and the
// datapath. The sequencer takes the master side: it drives the ROM address
// and the decoded instruction. Control inputs and ROM fields come back to it.
interface fetch_sequencer_if;
  // Run control and datapath feedback
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;

  // Instruction ROM fields for the word at pc_out
  logic        rom_format;
  logic [3:0]  rom_opcode;
  logic        rom_sign;
  logic [2:0]  rom_operand;

  // Fetch address and latched instruction register
  logic [15:0] pc_out;
  logic        ir_valid;
  logic        ir_format;
  logic [3:0]  ir_opcode;
  logic        ir_sign;
  logic [2:0]  ir_operand;
  logic [7:0]  ir_immediate;

  // Run status
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] instr_count;

  modport master (
    input  start, stall, branch_taken, branch_target,
    input  rom_format, rom_opcode, rom_sign, rom_operand,
    output pc_out, ir_valid, ir_format, ir_opcode, ir_sign, ir_operand,
    output ir_immediate, busy, done, err, instr_count
  );

  modport slave (
    output start, stall, branch_taken, branch_target,
    output rom_format, rom_opcode, rom_sign, rom_operand,
    input  pc_out, ir_valid, ir_format, ir_opcode, ir_sign, ir_operand,
    input  ir_immediate, busy, done, err, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 9-bit-instruction core.
// Each instruction is fetched in one FETCH cycle, when the ROM word is latched
// into the IR. The next EXEC cycle presents the IR to the datapath until it
// is no longer stalled. Taken branches redirect the PC. The run halts on the
// HALT encoding, or with err set when the next PC would pass the last ROM
// address.
module fetch_sequencer #(
  parameter logic [15:0] START_PC   = 16'd0,
  parameter logic [8:0]  HALT_INSTR = 9'h1B0,
  parameter logic [15:0] PC_MAX     = 16'd119
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] pc;
  logic [15:0] count;
  logic [8:0]  ir;
  logic        err_q;

  // Strobes from the controller to the datapath registers
  logic        do_restart;
  logic        do_load_ir;
  logic        do_retire;
  logic        do_overrun;

  logic [8:0]  rom_word;
  logic [15:0] pc_chosen;
  logic        pc_overrun;

  assign rom_word   = {bus.rom_format, bus.rom_opcode, bus.rom_sign, bus.rom_operand};
  // The +1 wraps modulo 2^16. Any out-of-range address is caught by the PC_MAX compare.
  assign pc_chosen  = bus.branch_taken ? bus.branch_target : pc + 16'd1;
  assign pc_overrun = (pc_chosen > PC_MAX);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, whatever the process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    do_restart = 1'b0;
    do_load_ir = 1'b0;
    do_retire  = 1'b0;
    do_overrun = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          do_restart = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        do_load_ir = 1'b1;
        state_next = (rom_word == HALT_INSTR) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        // While stalled, branch_taken is ignored and nothing moves.
        if (!bus.stall) begin
          do_retire = 1'b1;
          if (pc_overrun) begin
            do_overrun = 1'b1;
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // PC, instruction register, retire counter and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= START_PC;
      ir    <= 9'd0;
      count <= 16'd0;
      err_q <= 1'b0;
    end else begin
      if (do_restart) begin
        pc    <= START_PC;
        count <= 16'd0;
        err_q <= 1'b0;
      end
      if (do_load_ir) begin
        ir <= rom_word;
      end
      if (do_retire) begin
        count <= count + 16'd1;
        // An overrunning fetch keeps the PC at the instruction that caused it.
        if (do_overrun) begin
          err_q <= 1'b1;
        end else begin
          pc <= pc_chosen;
        end
      end
    end
  end

  assign bus.pc_out       = pc;
  assign bus.ir_format    = ir[8];
  assign bus.ir_opcode    = ir[7:4];
  assign bus.ir_sign      = ir[3];
  assign bus.ir_operand   = ir[2:0];
  assign bus.ir_immediate = ir[7:0];
  assign bus.instr_count  = count;
  assign bus.err          = err_q;

  // The status flags decode from state alone.
  assign bus.ir_valid = (state == S_EXEC);
  assign bus.busy     = (state == S_FETCH) || (state == S_EXEC);
  assign bus.done     = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer.
// A run-level reference model tracks what the sequencer must present, from the
// fetch/execute/halt rules. A compare process checks every output against it
// on each falling edge. Directed scenarios add hand-computed literal checks.
module tb_fetch_sequencer;

  localparam logic [15:0] START_PC   = 16'd0;
  localparam logic [8:0]  HALT_INSTR = 9'h1B0;
  localparam logic [15:0] PC_MAX     = 16'd119;

  logic clk;
  logic rst_n;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .START_PC   (START_PC),
    .HALT_INSTR (HALT_INSTR),
    .PC_MAX     (PC_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction ROM
  logic [8:0] rom_mem [0:255];
  logic [8:0] rom_word;

  always_comb begin
    rom_word = 9'h000;
    if (bus.pc_out <= 16'd255) rom_word = rom_mem[bus.pc_out[7:0]];
  end
  assign {bus.rom_format, bus.rom_opcode, bus.rom_sign, bus.rom_operand} = rom_word;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: where the run is, and what it has produced so far.
  bit          m_fetching;
  bit          m_executing;
  bit          m_halted;
  logic [15:0] m_pc;
  logic [8:0]  m_ir;
  logic [15:0] m_count;
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    logic [8:0]  word;
    logic [15:0] target;
    if (!rst_n) begin
      m_fetching  = 1'b0;
      m_executing = 1'b0;
      m_halted    = 1'b0;
      m_pc        = START_PC;
      m_ir        = 9'h000;
      m_count     = 16'd0;
      m_err       = 1'b0;
    end else if (m_fetching) begin
      word       = rom_mem[m_pc[7:0]];
      m_ir       = word;
      m_fetching = 1'b0;
      if (word == HALT_INSTR) m_halted = 1'b1;
      else                    m_executing = 1'b1;
    end else if (m_executing) begin
      if (!bus.stall) begin
        m_count     = m_count + 16'd1;
        m_executing = 1'b0;
        target      = bus.branch_taken ? bus.branch_target : m_pc + 16'd1;
        if (target > PC_MAX) begin
          m_err    = 1'b1;
          m_halted = 1'b1;
        end else begin
          m_pc       = target;
          m_fetching = 1'b1;
        end
      end
    end else if (bus.start) begin
      m_halted   = 1'b0;
      m_fetching = 1'b1;
      m_pc       = START_PC;
      m_count    = 16'd0;
      m_err      = 1'b0;
    end
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    check("pc_out",       32'(bus.pc_out),       32'(m_pc));
    check("ir_valid",     32'(bus.ir_valid),     32'(m_executing));
    check("busy",         32'(bus.busy),         32'(m_fetching | m_executing));
    check("done",         32'(bus.done),         32'(m_halted));
    check("err",          32'(bus.err),          32'(m_err));
    check("instr_count",  32'(bus.instr_count),  32'(m_count));
    check("ir_format",    32'(bus.ir_format),    32'(m_ir[8]));
    check("ir_opcode",    32'(bus.ir_opcode),    32'(m_ir[7:4]));
    check("ir_sign",      32'(bus.ir_sign),      32'(m_ir[3]));
    check("ir_operand",   32'(bus.ir_operand),   32'(m_ir[2:0]));
    check("ir_immediate", 32'(bus.ir_immediate), 32'(m_ir[7:0]));
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Advance until the sequencer presents the instruction at pc in EXEC
  task automatic wait_exec(input logic [15:0] pc);
    int n;
    n = 0;
    while (!(bus.ir_valid === 1'b1 && bus.pc_out === pc) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL wait_exec: EXEC at pc %0d not reached, pc_out=%0d", pc, bus.pc_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = {1'b0, 8'(i) ^ 8'h5A};
    rom_mem[0]   = 9'h000;
    rom_mem[1]   = 9'h178;
    rom_mem[2]   = HALT_INSTR;
    rom_mem[119] = HALT_INSTR;

    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst pc_out",      32'(bus.pc_out),      32'd0);
    check("rst ir_valid",    32'(bus.ir_valid),    32'd0);
    check("rst busy",        32'(bus.busy),        32'd0);
    check("rst done",        32'(bus.done),        32'd0);
    check("rst instr_count", 32'(bus.instr_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two instructions then HALT at pc 2; ir_valid on cycles 2 and 4
    pulse_start();
    check("t1 c1 ir_valid", 32'(bus.ir_valid), 32'd0);
    check("t1 c1 busy",     32'(bus.busy),     32'd1);
    check("t1 c1 pc",       32'(bus.pc_out),   32'd0);
    @(negedge clk);
    check("t1 c2 ir_valid", 32'(bus.ir_valid), 32'd1);
    check("t1 c2 opcode",   32'(bus.ir_opcode), 32'd0);
    @(negedge clk);
    check("t1 c3 ir_valid", 32'(bus.ir_valid), 32'd0);
    check("t1 c3 pc",       32'(bus.pc_out),   32'd1);
    check("t1 c3 count",    32'(bus.instr_count), 32'd1);
    @(negedge clk);
    check("t1 c4 ir_valid", 32'(bus.ir_valid),     32'd1);
    check("t1 c4 imm",      32'(bus.ir_immediate), 32'h78);
    check("t1 c4 format",   32'(bus.ir_format),    32'd1);
    check("t1 c4 sign",     32'(bus.ir_sign),      32'd1);
    @(negedge clk);
    check("t1 c5 pc",       32'(bus.pc_out),      32'd2);
    check("t1 c5 count",    32'(bus.instr_count), 32'd2);
    @(negedge clk);
    check("t1 halt done",   32'(bus.done),        32'd1);
    check("t1 halt err",    32'(bus.err),         32'd0);
    check("t1 halt count",  32'(bus.instr_count), 32'd2);
    check("t1 halt valid",  32'(bus.ir_valid),    32'd0);

    // 2: taken branch from pc 5 to 40
    rom_mem[2] = 9'h025;
    pulse_start();
    wait_exec(16'd5);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'd40;
    @(negedge clk);
    bus.branch_taken = 1'b0;
    check("t2 branch pc", 32'(bus.pc_out),      32'd40);
    check("t2 count",     32'(bus.instr_count), 32'd6);

    // 3: three stalled EXEC cycles with branch_taken toggling, then one retire
    @(negedge clk);
    check("t3 exec valid", 32'(bus.ir_valid), 32'd1);
    bus.stall         = 1'b1;
    bus.branch_target = 16'd77;
    for (int i = 0; i < 3; i++) begin
      bus.branch_taken = (i % 2 == 0);
      @(negedge clk);
      check("t3 stall valid", 32'(bus.ir_valid),     32'd1);
      check("t3 stall pc",    32'(bus.pc_out),       32'd40);
      check("t3 stall count", 32'(bus.instr_count),  32'd6);
      check("t3 stall imm",   32'(bus.ir_immediate), 32'(8'd40 ^ 8'h5A));
    end
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("t3 release pc",    32'(bus.pc_out),      32'd41);
    check("t3 release count", 32'(bus.instr_count), 32'd7);
    @(negedge clk);
    check("t3 next exec count", 32'(bus.instr_count), 32'd7);

    // 4: branch to the last ROM address, which holds HALT, then restart
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'd119;
    @(negedge clk);
    bus.branch_taken = 1'b0;
    check("t4 fetch pc", 32'(bus.pc_out), 32'd119);
    @(negedge clk);
    check("t4 done",  32'(bus.done),        32'd1);
    check("t4 err",   32'(bus.err),         32'd0);
    check("t4 count", 32'(bus.instr_count), 32'd8);
    pulse_start();
    check("t4 restart pc",    32'(bus.pc_out),      32'(START_PC));
    check("t4 restart count", 32'(bus.instr_count), 32'd0);
    check("t4 restart done",  32'(bus.done),        32'd0);

    // 5: branch past PC_MAX halts with err and keeps the PC
    wait_exec(16'd0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'd200;
    @(negedge clk);
    bus.branch_taken = 1'b0;
    check("t5 done",  32'(bus.done),        32'd1);
    check("t5 err",   32'(bus.err),         32'd1);
    check("t5 pc",    32'(bus.pc_out),      32'd0);
    check("t5 count", 32'(bus.instr_count), 32'd1);

    // 6: a start held into FETCH is ignored; async reset mid-EXEC
    bus.start = 1'b1;
    @(negedge clk);
    check("t6 err cleared", 32'(bus.err), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("t6 start ignored", 32'(bus.ir_valid), 32'd1);
    wait_exec(16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async pc",       32'(bus.pc_out),      32'd0);
    check("t6 async valid",    32'(bus.ir_valid),    32'd0);
    check("t6 async busy",     32'(bus.busy),        32'd0);
    check("t6 async count",    32'(bus.instr_count), 32'd0);
    check("t6 async imm",      32'(bus.ir_immediate), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6 idle busy", 32'(bus.busy), 32'd0);
    check("t6 idle done", 32'(bus.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
